phy_tx_lane_serializer: RTL and testbench
=========================================

// Module: phy_tx_lane_serializer
// PURPOSE
//  Parametrised PHY transmit datapath. Accepts frames of NUM_LANES words (DATA_W bits each) with per-lane valids
//  and stripes them round-robin (lane 0 first) onto one serial line, MSB first, one bit per clk.
//  Emits SYNC_SYMS COM symbols after reset, substitutes IDL for invalid lanes, and sends an all-IDL frame on underrun.
//  Sits between the lane-mux stage and the serial PHY link; its output feeds the receiver's COM-based symbol aligner.
// PARAMETERS
//  NUM_LANES  4      lanes per frame (>=1)
//  DATA_W     8      bits per symbol (>=2)
//  SYNC_SYMS  4      COM symbols sent after reset before ACTIVE (>=1)
//  COM_SYM    8'hBC  comma symbol, DATA_W bits
//  IDL_SYM    8'h7C  idle symbol, DATA_W bits
// PORTS
//  clk          in   1                  single clock; all logic on posedge
//  reset        in   1                  synchronous, active-low
//  frm_valid    in   1                  frame offered
//  frm_ready    out  1                  frame accepted when frm_valid & frm_ready at posedge
//  data_in      in   NUM_LANES*DATA_W   lane k = data_in[k*DATA_W +: DATA_W]
//  lane_valid   in   NUM_LANES          per-lane qualifier, captured with the frame
//  tx_serial    out  1                  serial bit, registered
//  tx_sym_start out  1                  high while tx_serial carries a symbol's MSB
//  tx_active    out  1                  0 during SYNC, 1 in ACTIVE
//  underrun     out  1                  1-cycle pulse when an ACTIVE frame boundary finds no held frame
// BEHAVIOUR
//  - reset==0 at posedge: state=SYNC, counters=0, holding reg empty, tx_serial=0, tx_sym_start=0, tx_active=0,
//    underrun=0, frm_ready=0. Reset mid-symbol aborts the symbol; any held frame is discarded.
//  - frm_ready = reset & ~hold_full | (reset & hold_full & frame_load). Combinational, so back-to-back frames are accepted with no gap.
//  - Counters: bit_cnt 0..DATA_W-1 ($clog2(DATA_W) bits); slot_cnt 0..NUM_LANES-1 (max(1,$clog2(NUM_LANES)) bits);
//    sync_cnt 0..SYNC_SYMS-1. All wrap to 0. Shift register is DATA_W bits and shifts left each cycle.
//  - Symbol load: on the first posedge with reset==1, and on every posedge with bit_cnt==DATA_W-1.
//    tx_serial shows the new MSB after that edge; tx_sym_start=1 for that cycle.
//  - FSM SYNC: every loaded symbol is COM_SYM. After the SYNC_SYMS-th COM completes, go to ACTIVE
//    at slot_cnt=0, aligned to a frame boundary.
//  - FSM ACTIVE: frame boundary = load with slot_cnt==NUM_LANES-1 (or the SYNC->ACTIVE transition).
//    At the boundary:
//    - If the holding reg is full: move it to the frame reg (frame_load), clear hold_full, then set it again
//      if a new frame is accepted in the same cycle.
//    - If the holding reg is empty: the frame reg is loaded with all lane_valid=0 and underrun pulses.
//  - Slot s symbol = frame_valid[s] ? frame_data[s] : IDL_SYM.
//  - Latency: an accepted frame starts at the next frame boundary after the accept edge,
//    i.e. at least 1 cycle and at most NUM_LANES*DATA_W cycles.
//  - Simultaneous accept and boundary: the held frame is loaded and the new frame is held; no loss, no duplication.
//  - Frames accepted during SYNC are held and transmitted as the first ACTIVE frame.
//  - Holding reg full with frm_valid=1 and no boundary: frm_ready=0 and data_in/lane_valid are ignored.
//  - No FSM transition back to SYNC except via reset.
// STRUCTURE
//  - phy_pkg: COM/IDL default constants, state enum {SYNC, ACTIVE}, and a clog2 helper.
//  - Sub-module phy_symbol_shifter: DATA_W load/shift register plus bit_cnt.
//    Generates sym_last (bit_cnt==DATA_W-1) and tx_sym_start.
//  - Top level: FSM, slot/sync counters, holding reg, frame reg, and the lane symbol mux.
// TESTING  (NUM_LANES=4, DATA_W=8, SYNC_SYMS=4)
//  - Reset low 3 cycles, then high, frm_valid=0 -> 4 x 8'hBC (32 cycles, tx_active=0), then continuous 8'h7C.
//    tx_active=1, and underrun pulses every 32 cycles.
//  - Hold frame {FF,EE,DD,CC} with lane_valid=4'hF during SYNC -> first ACTIVE symbols are FF,EE,DD,CC MSB first.
//    Check tx_sym_start every 8 cycles and no underrun on that boundary.
//  - Frame {55,55,77,55} with lane_valid=4'b0100 -> serial 7C,7C,77,7C.
//  - Frames {FF,EE,DD,CC} then {BB,AA,99,88}, frm_valid held high -> first accepted, frm_ready=0 until the boundary,
//    second accepted on the boundary edge. Output is 8 contiguous symbols with no IDL between them.
//  - reset=0 at bit 3 of the symbol AA -> tx_serial=0 after that edge and frm_ready=0.
//    After release: 4 x BC, the held frame is lost, then 7C.
//  - NUM_LANES=1, DATA_W=10, COM=10'h17C -> 1 COM x SYNC_SYMS, then each frame is 1 symbol of 10 bits.
//    underrun pulses every 10 cycles when idle.

Source files
------------

// File: rtl/phy_tx_lane_serializer_pkg.sv
// Shared constants, state type and sizing helper for the PHY TX lane serializer.
package phy_tx_lane_serializer_pkg;

  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  localparam logic [7:0] IDL_SYM_DEF = 8'h7C;

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // Counter width for a 0..v-1 range, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/phy_tx_lane_serializer_if.sv
// Frame handshake from the lane-mux stage into the serializer.
interface phy_tx_lane_serializer_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W    = 8
);

  logic                          frm_valid;
  logic                          frm_ready;
  logic [NUM_LANES*DATA_W-1:0]   data_in;
  logic [NUM_LANES-1:0]          lane_valid;

  modport master (output frm_valid, output data_in, output lane_valid, input frm_ready);
  modport slave  (input frm_valid, input data_in, input lane_valid, output frm_ready);

endinterface

// File: rtl/phy_symbol_shifter.sv
// Symbol load/shift register: emits one bit per clk, MSB first, and requests the next symbol.
module phy_symbol_shifter
  import phy_tx_lane_serializer_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sym_in,
  output logic              load_c,
  output logic              tx_serial,
  output logic              tx_sym_start
);

  localparam int unsigned CNT_W = clog2_min1(DATA_W);

  logic              started;
  logic              sym_last_c;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_q;

  // A new symbol is taken on the first cycle out of reset and after each symbol's last bit.
  assign sym_last_c = (bit_cnt == CNT_W'(DATA_W - 1));
  assign load_c     = ~started | sym_last_c;
  assign tx_serial  = shift_q[DATA_W-1];

  // Load on symbol boundary, otherwise shift left and count bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      started      <= 1'b0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      tx_sym_start <= 1'b0;
    end else begin
      started      <= 1'b1;
      tx_sym_start <= load_c;
      if (load_c) begin
        shift_q <= sym_in;
        bit_cnt <= '0;
      end else begin
        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/phy_tx_lane_serializer.sv
// PHY TX datapath: COM sync preamble, then round-robin lane striping with IDL fill and underrun.
module phy_tx_lane_serializer
  import phy_tx_lane_serializer_pkg::*;
#(
  parameter int unsigned       NUM_LANES = 4,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       SYNC_SYMS = 4,
  parameter logic [DATA_W-1:0] COM_SYM   = DATA_W'(COM_SYM_DEF),
  parameter logic [DATA_W-1:0] IDL_SYM   = DATA_W'(IDL_SYM_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  phy_tx_lane_serializer_if.slave  frm_if,
  output logic                     tx_serial,
  output logic                     tx_sym_start,
  output logic                     tx_active,
  output logic                     underrun
);

  localparam int unsigned SLOT_W = clog2_min1(NUM_LANES);
  localparam int unsigned SYNC_W = clog2_min1(SYNC_SYMS);
  localparam int unsigned FRM_W  = NUM_LANES * DATA_W;

  tx_state_e            state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [SYNC_W-1:0]    sync_q, sync_d;
  logic                 sync_done_q, sync_done_d;
  logic                 hold_full_q, hold_full_d;
  logic [FRM_W-1:0]     hold_data_q, hold_data_d;
  logic [NUM_LANES-1:0] hold_valid_q, hold_valid_d;
  logic [FRM_W-1:0]     frame_data_q, frame_data_d;
  logic [NUM_LANES-1:0] frame_valid_q, frame_valid_d;
  logic                 underrun_d;
  logic                 load_c;
  logic                 boundary_c;
  logic                 frame_load_c;
  logic                 accept_c;
  logic [DATA_W-1:0]    sym_c;

  // Frame boundary: leaving SYNC after the last COM, or finishing the last lane slot.
  assign boundary_c = load_c &
                      (((state_q == ST_SYNC) & sync_done_q) |
                       ((state_q == ST_ACTIVE) & (slot_q == SLOT_W'(NUM_LANES - 1))));
  assign frame_load_c     = boundary_c & hold_full_q;
  assign frm_if.frm_ready = reset & (~hold_full_q | frame_load_c);
  assign accept_c         = frm_if.frm_valid & frm_if.frm_ready;
  assign tx_active        = (state_q == ST_ACTIVE);

  // State, counters, holding and frame registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_SYNC;
      slot_q        <= '0;
      sync_q        <= '0;
      sync_done_q   <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      hold_valid_q  <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= '0;
      underrun      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      sync_q        <= sync_d;
      sync_done_q   <= sync_done_d;
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      hold_valid_q  <= hold_valid_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      underrun      <= underrun_d;
    end
  end

  // Next state, counter stepping, frame hand-over and holding-register capture.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    sync_d        = sync_q;
    sync_done_d   = sync_done_q;
    hold_full_d   = hold_full_q;
    hold_data_d   = hold_data_q;
    hold_valid_d  = hold_valid_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    underrun_d    = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (load_c) begin
          if (sync_done_q) begin
            state_d     = ST_ACTIVE;
            slot_d      = '0;
            sync_done_d = 1'b0;
          end else begin
            sync_done_d = (sync_q == SYNC_W'(SYNC_SYMS - 1));
            sync_d      = sync_done_d ? '0 : sync_q + SYNC_W'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (load_c) begin
          if (slot_q == SLOT_W'(NUM_LANES - 1)) begin
            slot_d = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (boundary_c) begin
      if (hold_full_q) begin
        frame_data_d  = hold_data_q;
        frame_valid_d = hold_valid_q;
        hold_full_d   = 1'b0;
      end else begin
        frame_valid_d = '0;
        underrun_d    = 1'b1;
      end
    end

    if (accept_c) begin
      hold_full_d  = 1'b1;
      hold_data_d  = frm_if.data_in;
      hold_valid_d = frm_if.lane_valid;
    end
  end

  // Symbol for the slot about to start; COM while syncing, IDL for unqualified lanes.
  always_comb begin
    sym_c = COM_SYM;
    if (state_d == ST_ACTIVE) begin
      sym_c = IDL_SYM;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        if ((slot_d == SLOT_W'(k)) && frame_valid_d[k]) begin
          sym_c = frame_data_d[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  phy_symbol_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk          (clk),
    .reset        (reset),
    .sym_in       (sym_c),
    .load_c       (load_c),
    .tx_serial    (tx_serial),
    .tx_sym_start (tx_sym_start)
  );

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Bench for phy_tx_lane_serializer: 4x8 instance (A) and 1x10 instance (B) against a stream model.
module tb_phy_tx_lane_serializer;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic ser_a, ss_a, act_a, und_a;
  logic ser_b, ss_b, act_b, und_b;

  phy_tx_lane_serializer_if #(.NUM_LANES(4), .DATA_W(8))  if_a ();
  phy_tx_lane_serializer_if #(.NUM_LANES(1), .DATA_W(10)) if_b ();

  phy_tx_lane_serializer #(
    .NUM_LANES(4), .DATA_W(8), .SYNC_SYMS(4), .COM_SYM(8'hBC), .IDL_SYM(8'h7C)
  ) dut_a (
    .clk(clk), .reset(rst_a), .frm_if(if_a.slave),
    .tx_serial(ser_a), .tx_sym_start(ss_a), .tx_active(act_a), .underrun(und_a)
  );

  phy_tx_lane_serializer #(
    .NUM_LANES(1), .DATA_W(10), .SYNC_SYMS(2), .COM_SYM(10'h17C), .IDL_SYM(10'h0F3)
  ) dut_b (
    .clk(clk), .reset(rst_b), .frm_if(if_b.slave),
    .tx_serial(ser_b), .tx_sym_start(ss_b), .tx_active(act_b), .underrun(und_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stream model: symbol n = edge/DATA_W; first SYNC_SYMS are COM, then frames of NUM_LANES symbols.
  int  m_nl [2] = '{4, 1};
  int  m_dw [2] = '{8, 10};
  int  m_ss [2] = '{4, 2};
  int  m_com[2] = '{32'hBC, 32'h17C};
  int  m_idl[2] = '{32'h7C, 32'h0F3};
  bit  m_init[2];
  int  m_e[2];
  bit  m_hf[2];
  int  m_hd[2][4];
  bit  m_hv[2][4];
  int  m_cd[2][4];
  bit  m_cv[2][4];
  int  m_in_d[2][4];
  bit  m_in_v[2][4];
  bit  x_ser[2], x_ss[2], x_act[2], x_und[2];

  int          ea;
  logic        rdy_a_seen;
  int          cap_mode;
  logic [63:0] cap;
  int          cap_n;
  int          und_cnt_a, und_cnt_b;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  lv;
    logic [31:0] exp_syms;
    string       name;
  } row_t;
  row_t rows[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_boundary(input int i, input int e);
    int n;
    n = e / m_dw[i];
    return (e % m_dw[i] == 0) && (n >= m_ss[i]) && ((n - m_ss[i]) % m_nl[i] == 0);
  endfunction

  function automatic bit m_ready(input int i, input logic rst);
    return (rst === 1'b1) && (!m_hf[i] || m_boundary(i, m_e[i]));
  endfunction

  task automatic m_edge(input int i, input logic rst, input logic fv);
    int  e, n, b, sym, slot;
    bit  rdy, bnd;
    if (rst !== 1'b1) begin
      m_init[i] = 1'b1;
      m_e[i]    = 0;
      m_hf[i]   = 1'b0;
      for (int k = 0; k < 4; k++) m_cv[i][k] = 1'b0;
      x_ser[i] = 0; x_ss[i] = 0; x_act[i] = 0; x_und[i] = 0;
      return;
    end
    if (!m_init[i]) return;
    e   = m_e[i];
    rdy = m_ready(i, 1'b1);
    bnd = m_boundary(i, e);
    x_und[i] = 1'b0;
    if (bnd) begin
      if (m_hf[i]) begin
        for (int k = 0; k < 4; k++) begin
          m_cd[i][k] = m_hd[i][k];
          m_cv[i][k] = m_hv[i][k];
        end
        m_hf[i] = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) m_cv[i][k] = 1'b0;
        x_und[i] = 1'b1;
      end
    end
    if (fv === 1'b1 && rdy) begin
      for (int k = 0; k < 4; k++) begin
        m_hd[i][k] = m_in_d[i][k];
        m_hv[i][k] = m_in_v[i][k];
      end
      m_hf[i] = 1'b1;
    end
    n = e / m_dw[i];
    b = e % m_dw[i];
    if (n < m_ss[i]) begin
      sym = m_com[i];
    end else begin
      slot = (n - m_ss[i]) % m_nl[i];
      sym  = m_cv[i][slot] ? m_cd[i][slot] : m_idl[i];
    end
    x_ser[i] = 1'((sym >> (m_dw[i] - 1 - b)) & 1);
    x_ss[i]  = (b == 0);
    x_act[i] = (n >= m_ss[i]);
    m_e[i]   = e + 1;
  endtask

  // One clock: ready check before the edge, model step at the edge, output checks just after.
  task tick();
    @(negedge clk);
    rdy_a_seen = if_a.frm_ready;
    if (m_init[0]) chk("rdy_a", 64'(if_a.frm_ready), 64'(m_ready(0, rst_a)));
    if (m_init[1]) chk("rdy_b", 64'(if_b.frm_ready), 64'(m_ready(1, rst_b)));
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      m_in_d[0][k] = int'(if_a.data_in[k*8 +: 8]);
      m_in_v[0][k] = if_a.lane_valid[k];
      m_in_d[1][k] = 0;
      m_in_v[1][k] = 1'b0;
    end
    m_in_d[1][0] = int'(if_b.data_in);
    m_in_v[1][0] = if_b.lane_valid[0];
    m_edge(0, rst_a, if_a.frm_valid);
    m_edge(1, rst_b, if_b.frm_valid);
    if (rst_a === 1'b1) ea++; else ea = 0;
    #1;
    if (m_init[0]) begin
      chk("ser_a", 64'(ser_a), 64'(x_ser[0]));
      chk("sstart_a", 64'(ss_a), 64'(x_ss[0]));
      chk("active_a", 64'(act_a), 64'(x_act[0]));
      chk("underrun_a", 64'(und_a), 64'(x_und[0]));
    end
    if (m_init[1]) begin
      chk("ser_b", 64'(ser_b), 64'(x_ser[1]));
      chk("sstart_b", 64'(ss_b), 64'(x_ss[1]));
      chk("active_b", 64'(act_b), 64'(x_act[1]));
      chk("underrun_b", 64'(und_b), 64'(x_und[1]));
    end
    if ((cap_mode == 1 && act_a === 1'b1) || cap_mode == 2) begin
      cap = {cap[62:0], ser_a};
      cap_n++;
    end
    if (und_a === 1'b1) und_cnt_a++;
    if (und_b === 1'b1) und_cnt_b++;
  endtask

  task reset_a();
    rst_a = 1'b0;
    if_a.frm_valid = 1'b0;
    repeat (3) tick();
    rst_a = 1'b1;
  endtask

  // Offer a frame on A until the DUT takes it; returns the accepting edge index.
  task offer_a(input logic [31:0] d, input logic [3:0] lv, output int acc_edge);
    bit got;
    got = 1'b0;
    acc_edge = -1;
    if_a.data_in    = d;
    if_a.lane_valid = lv;
    if_a.frm_valid  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rdy_a_seen === 1'b1) begin
        got = 1'b1;
        acc_edge = ea - 1;
        break;
      end
    end
    if_a.frm_valid = 1'b0;
    if (!got) chk("offer_timeout", 64'd0, 64'd1);
  endtask

  task capture_active(input int nbits, input string nm);
    cap = '0;
    cap_n = 0;
    cap_mode = 1;
    for (int c = 0; c < 400 && cap_n < nbits; c++) tick();
    cap_mode = 0;
    if (cap_n < nbits) chk({nm, "_timeout"}, 64'(cap_n), 64'(nbits));
  endtask

  initial begin
    int acc;
    rows[0] = '{32'hCCDDEEFF, 4'hF,    32'hFFEEDDCC, "all_valid"};
    rows[1] = '{32'h55775555, 4'b0100, 32'h7C7C777C, "lane2_only"};
    rows[2] = '{32'h78563412, 4'b1001, 32'h127C7C78, "lanes_0_3"};
    rows[3] = '{32'hD4C3B2A1, 4'b0000, 32'h7C7C7C7C, "none_valid"};
    rows[4] = '{32'hFF007CBC, 4'b0110, 32'h7C7C007C, "lanes_1_2"};

    ea = 0; cap_mode = 0; cap = '0; cap_n = 0; und_cnt_a = 0; und_cnt_b = 0;
    rst_a = 1'b0; rst_b = 1'b0;
    if_a.frm_valid = 1'b0; if_a.data_in = '0; if_a.lane_valid = '0;
    if_b.frm_valid = 1'b0; if_b.data_in = '0; if_b.lane_valid = '0;
    repeat (3) tick();
    chk("reset_ser_a", 64'(ser_a), 64'd0);
    chk("reset_ready_a", 64'(if_a.frm_ready), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1;

    // Idle after reset: sync preamble, then underrun every frame period.
    repeat (32) tick();
    chk("sync_inactive_a", 64'(act_a), 64'd0);
    und_cnt_a = 0;
    repeat (96) tick();
    chk("idle_underruns_a", 64'(und_cnt_a), 64'd3);
    und_cnt_b = 0;
    repeat (100) tick();
    chk("idle_underruns_b", 64'(und_cnt_b), 64'd10);

    // Table: one frame held during SYNC becomes the first ACTIVE frame.
    foreach (rows[r]) begin
      reset_a();
      und_cnt_a = 0;
      offer_a(rows[r].data, rows[r].lv, acc);
      chk({rows[r].name, "_acc_edge"}, 64'(acc), 64'd0);
      capture_active(32, rows[r].name);
      chk(rows[r].name, cap[31:0], 64'(rows[r].exp_syms));
      chk({rows[r].name, "_no_und"}, 64'(und_cnt_a), 64'd0);
    end

    // Back-to-back: second frame waits for the boundary, then 8 contiguous symbols.
    reset_a();
    cap = '0; cap_n = 0; cap_mode = 1; und_cnt_a = 0;
    offer_a(32'hCCDDEEFF, 4'hF, acc);
    offer_a(32'h8899AABB, 4'hF, acc);
    chk("b2b_second_acc_edge", 64'(acc), 64'd32);
    for (int c = 0; c < 200 && cap_n < 64; c++) tick();
    cap_mode = 0;
    chk("b2b_stream", cap, 64'hFFEEDDCCBBAA9988);
    chk("b2b_no_und", 64'(und_cnt_a), 64'd0);

    // Reset in the middle of symbol AA with a third frame held.
    reset_a();
    offer_a(32'hCCDDEEFF, 4'hF, acc);
    offer_a(32'h8899AABB, 4'hF, acc);
    offer_a(32'h44332211, 4'hF, acc);
    chk("third_acc_edge", 64'(acc), 64'd64);
    for (int c = 0; c < 200 && (ea - 1) < 74; c++) tick();
    rst_a = 1'b0;
    tick();
    chk("midsym_rst_ser", 64'(ser_a), 64'd0);
    chk("midsym_rst_ready", 64'(if_a.frm_ready), 64'd0);
    tick();
    tick();
    rst_a = 1'b1;
    cap = '0; cap_n = 0; cap_mode = 2;
    repeat (64) tick();
    cap_mode = 0;
    chk("post_rst_stream", cap, 64'hBCBCBCBC7C7C7C7C);

    // Random traffic and occasional resets on both instances.
    for (int c = 0; c < 3000; c++) begin
      rst_a = ($urandom_range(0, 499) != 0);
      rst_b = ($urandom_range(0, 499) != 0);
      if_a.frm_valid  = ($urandom_range(0, 3) != 0);
      if_a.data_in    = 32'($urandom());
      if_a.lane_valid = 4'($urandom());
      if_b.frm_valid  = ($urandom_range(0, 2) == 0);
      if_b.data_in    = 10'($urandom());
      if_b.lane_valid = 1'($urandom());
      tick();
    end
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.frm_valid = 1'b0; if_b.frm_valid = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
